// File: rtl/cpu_pkg.sv
// Shared fetch-unit constants so the PC holding register and its users agree
// on program-counter width and reset vector.
package cpu_pkg;
  localparam int                  PC_WIDTH = 10;
  localparam logic [PC_WIDTH-1:0] PC_RESET = 10'd0;
endpackage

// File: rtl/dff_en_arst.sv
// Single-bit storage flop with load enable and asynchronous active-low reset.
module dff_en_arst #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic d_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (en_i) q_d = d_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= RESET_VALUE;
    else         q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/register_10bit.sv
// Clock-enabled holding register (program counter in the fetch unit); each bit
// is its own enable flop so the per-bit reset value comes straight from RESET_VALUE.
module register_10bit
  import cpu_pkg::*;
#(
  parameter int               WIDTH       = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_en_arst #(
      .RESET_VALUE(RESET_VALUE[i])
    ) u_bit (
      .clk_i (clk),
      .rst_ni(reset),
      .en_i  (en),
      .d_i   (din[i]),
      .q_o   (dout[i])
    );
  end

endmodule

// File: tb/tb_register_10bit.sv
// Bench for register_10bit: directed vector table, reset corner sequences and
// randomized traffic against a behavioural model, on two reset-value variants.
module tb_register_10bit;

  localparam logic [9:0] RV_A = 10'h000;
  localparam logic [9:0] RV_B = 10'h200;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [9:0] din;
  logic [9:0] dout_a;
  logic [9:0] dout_b;

  int checks = 0;
  int errors = 0;

  // Behavioural view of each register's stored value.
  logic [9:0] model_a;
  logic [9:0] model_b;

  always #5 clk = ~clk;

  register_10bit dut_a (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .din  (din),
    .dout (dout_a)
  );

  register_10bit #(
    .WIDTH(10),
    .RESET_VALUE(RV_B)
  ) dut_b (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .din  (din),
    .dout (dout_b)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [9:0] din;
    logic [9:0] exp_a;
    logic [9:0] exp_b;
  } vec_t;

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%03h expected 0x%03h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive at the falling edge, clock once, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic e, input logic [9:0] d);
    @(negedge clk);
    reset = r;
    en    = e;
    din   = d;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    reset = 1'b0;
    en    = 1'b1;
    din   = 10'h2AA;

    // Power-up under reset, then loads, holds and boundary patterns.
    vecs.push_back('{1'b0, 1'b1, 10'h2AA, 10'h000, 10'h200});
    vecs.push_back('{1'b0, 1'b1, 10'h2AA, 10'h000, 10'h200});
    vecs.push_back('{1'b1, 1'b0, 10'h2AA, 10'h000, 10'h200});
    vecs.push_back('{1'b1, 1'b1, 10'h001, 10'h001, 10'h001});
    vecs.push_back('{1'b1, 1'b1, 10'h002, 10'h002, 10'h002});
    vecs.push_back('{1'b1, 1'b1, 10'h155, 10'h155, 10'h155});
    vecs.push_back('{1'b1, 1'b0, 10'h0F0, 10'h155, 10'h155});
    vecs.push_back('{1'b1, 1'b0, 10'h0F0, 10'h155, 10'h155});
    vecs.push_back('{1'b1, 1'b0, 10'h0F0, 10'h155, 10'h155});
    vecs.push_back('{1'b1, 1'b1, 10'h0F0, 10'h0F0, 10'h0F0});
    vecs.push_back('{1'b1, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF});
    vecs.push_back('{1'b1, 1'b1, 10'h000, 10'h000, 10'h000});
    vecs.push_back('{1'b1, 1'b1, 10'h200, 10'h200, 10'h200});
    vecs.push_back('{1'b1, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF});

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].din);
      chk($sformatf("vec%0d_a", i), dout_a, vecs[i].exp_a);
      chk($sformatf("vec%0d_b", i), dout_b, vecs[i].exp_b);
    end

    // Async reset 2 ns after an edge, no clock edge in between.
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_a", dout_a, 10'h000);
    chk("async_rst_b", dout_b, 10'h200);

    // A load attempt during reset is ignored.
    step(1'b0, 1'b1, 10'h123);
    chk("rst_ignores_load_a", dout_a, 10'h000);
    chk("rst_ignores_load_b", dout_b, 10'h200);

    // Release on the rising edge itself: that edge must not load.
    @(negedge clk);
    en  = 1'b1;
    din = 10'h07B;
    @(posedge clk);
    reset <= 1'b1;
    #1;
    chk("release_edge_a", dout_a, 10'h000);
    chk("release_edge_b", dout_b, 10'h200);
    @(posedge clk);
    #1;
    chk("first_load_a", dout_a, 10'h07B);
    chk("first_load_b", dout_b, 10'h07B);

    // Randomized traffic with occasional mid-cycle resets.
    model_a = dout_a;
    model_b = dout_b;
    for (int n = 0; n < 300; n++) begin
      logic       r;
      logic       e;
      logic [9:0] d;
      r = ($urandom_range(0, 9) != 0);
      e = 1'($urandom);
      d = 10'($urandom);
      @(negedge clk);
      reset = r;
      en    = e;
      din   = d;
      if (!r) begin
        model_a = RV_A;
        model_b = RV_B;
        #1;
        chk($sformatf("rnd%0d_async_a", n), dout_a, model_a);
        chk($sformatf("rnd%0d_async_b", n), dout_b, model_b);
      end
      @(posedge clk);
      if (r && e) begin
        model_a = d;
        model_b = d;
      end
      #1;
      chk($sformatf("rnd%0d_a", n), dout_a, model_a);
      chk($sformatf("rnd%0d_b", n), dout_b, model_b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
